// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single word memory.
// m0 is the instruction-fetch port and m1 is the data port. One transaction
// at a time moves through IDLE -> ISSUE -> WAIT -> RESP. A WAIT-state
// watchdog aborts the transaction with err_o if the memory never acknowledges.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ROUND_ROBIN    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_rd_en_i,
    input  logic        m0_wr_en_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    input  logic        m1_rd_en_i,
    input  logic        m1_wr_en_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);
    // Counter is at least 5 bits wide and always able to hold TIMEOUT_CYCLES.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;        // 0 = m0, 1 = m1
    logic             wr_q, wr_d;          // latched op: 1 = write
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             last_q, last_d;      // master granted last time
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      m0_data_q, m0_data_d;
    logic [31:0]      m1_data_q, m1_data_d;
    logic             m0_ack_q, m0_ack_d;
    logic             m1_ack_q, m1_ack_d;
    logic             err_q, err_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             busy_q, busy_d;

    logic             m0_req_s, m1_req_s, sel_s, sel_wr_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             done_s, timeout_s;
    logic [31:0]      resp_data_s;

    // Choose the winning master among the masters currently requesting.
    always_comb begin
        m0_req_s = m0_rd_en_i | m0_wr_en_i;
        m1_req_s = m1_rd_en_i | m1_wr_en_i;
        if (m0_req_s && m1_req_s) begin
            if (ROUND_ROBIN != 0) begin
                sel_s = ~last_q;
            end else begin
                sel_s = 1'b1;
            end
        end else begin
            sel_s = m1_req_s;
        end
        // A simultaneous read and write is executed as a write.
        sel_wr_s = sel_s ? m1_wr_en_i : m0_wr_en_i;
    end

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        m0_data_d   = m0_data_q;
        m1_data_d   = m1_data_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        err_d       = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        cnt_inc_s   = cnt_q + CNT_W'(1);
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        resp_data_s = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (m0_req_s || m1_req_s) begin
                    gnt_d    = sel_s;
                    wr_d     = sel_wr_s;
                    addr_d   = sel_s ? m1_addr_i : m0_addr_i;
                    wdata_d  = sel_s ? m1_data_i : m0_data_i;
                    mem_rd_d = ~sel_wr_s;
                    mem_wr_d = sel_wr_s;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    done_s      = 1'b1;
                    resp_data_s = wr_q ? 32'h0 : mem_data_i;
                end else if (cnt_inc_s == CNT_LIMIT) begin
                    done_s    = 1'b1;
                    timeout_s = 1'b1;
                    cnt_d     = cnt_inc_s;
                end else begin
                    cnt_d     = cnt_inc_s;
                end
                if (done_s) begin
                    state_d = ST_RESP;
                    err_d   = timeout_s;
                    if (gnt_q) begin
                        m1_ack_d  = 1'b1;
                        m1_data_d = resp_data_s;
                    end else begin
                        m0_ack_d  = 1'b1;
                        m0_data_d = resp_data_s;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                last_d  = gnt_q;
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            last_q    <= 1'b1;
            cnt_q     <= {CNT_W{1'b0}};
            m0_data_q <= 32'h0;
            m1_data_q <= 32'h0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            err_q     <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m0_data_q <= m0_data_d;
            m1_data_q <= m1_data_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
            err_q     <= err_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            busy_q    <= busy_d;
        end
    end

    assign m0_data_o   = m0_data_q;
    assign m1_data_o   = m1_data_q;
    assign m0_ack_o    = m0_ack_q;
    assign m1_ack_o    = m1_ack_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign mem_rd_en_o = mem_rd_q;
    assign mem_wr_en_o = mem_wr_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed transactions against a word-memory model,
// with expected responses queued at issue time and checked by a separate monitor.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_rd, m0_wr, m1_rd, m1_wr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_data_o, m1_data_o, mem_addr_o, mem_data_o;
    logic        m0_ack_o, m1_ack_o, err_o, busy_o, mem_rd_en_o, mem_wr_en_o;
    logic        ack_en, stray_ack, mem_ack_r;
    logic [31:0] mem_rdata_r;
    logic [31:0] mem [0:255];

    // Fixed-priority instance with its own masters and memory.
    logic        fp_m0_rd, fp_m1_rd;
    logic [31:0] fp_m0_data_o, fp_m1_data_o, fp_mem_addr_o, fp_mem_data_o, fp_rdata_r;
    logic        fp_m0_ack_o, fp_m1_ack_o, fp_err_o, fp_busy_o, fp_mem_rd_en_o, fp_mem_wr_en_o, fp_ack_r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        master;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    mem_arbiter #(.TIMEOUT_CYCLES(16), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .m0_rd_en_i(m0_rd), .m0_wr_en_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_rd_en_i(m1_rd), .m1_wr_en_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .err_o(err_o), .busy_o(busy_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_rdata_r), .mem_ack_i(mem_ack_r | stray_ack)
    );

    mem_arbiter #(.TIMEOUT_CYCLES(16), .ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst(rst),
        .m0_rd_en_i(fp_m0_rd), .m0_wr_en_i(1'b0), .m0_addr_i(32'h40), .m0_data_i(32'h0),
        .m0_data_o(fp_m0_data_o), .m0_ack_o(fp_m0_ack_o),
        .m1_rd_en_i(fp_m1_rd), .m1_wr_en_i(1'b0), .m1_addr_i(32'h80), .m1_data_i(32'h0),
        .m1_data_o(fp_m1_data_o), .m1_ack_o(fp_m1_ack_o),
        .err_o(fp_err_o), .busy_o(fp_busy_o),
        .mem_rd_en_o(fp_mem_rd_en_o), .mem_wr_en_o(fp_mem_wr_en_o),
        .mem_addr_o(fp_mem_addr_o), .mem_data_o(fp_mem_data_o),
        .mem_data_i(fp_rdata_r), .mem_ack_i(fp_ack_r)
    );

    // Word memory with a one-cycle registered acknowledge; ack_en=0 models a dead memory.
    always @(posedge clk) begin
        if (rst) begin
            mem_ack_r   <= 1'b0;
            mem_rdata_r <= 32'h0;
            mem[4]      <= 32'hDEADBEEF;
        end else begin
            mem_ack_r   <= ack_en & (mem_rd_en_o | mem_wr_en_o);
            mem_rdata_r <= mem[mem_addr_o[9:2]];
            if (mem_wr_en_o) begin
                mem[mem_addr_o[9:2]] <= mem_data_o;
            end
        end
    end

    // Memory for the fixed-priority instance: read data is address + 0x100.
    always @(posedge clk) begin
        if (rst) begin
            fp_ack_r   <= 1'b0;
            fp_rdata_r <= 32'h0;
        end else begin
            fp_ack_r   <= fp_mem_rd_en_o | fp_mem_wr_en_o;
            fp_rdata_r <= fp_mem_addr_o + 32'h100;
        end
    end

    // Monitor: every master ack pops the oldest expected response and compares.
    initial begin
        exp_t        e;
        logic        got_m;
        logic [31:0] got_d;
        forever begin
            @(negedge clk);
            if (m0_ack_o || m1_ack_o) begin
                checks++;
                got_m = m1_ack_o;
                got_d = m1_ack_o ? m1_data_o : m0_data_o;
                if (m0_ack_o && m1_ack_o) begin
                    errors++;
                    $display("FAIL ack_both: m0_ack=1 m1_ack=1, required one ack only");
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: m%0d ack data=0x%08h, required no ack", got_m, got_d);
                end else begin
                    e = sb_q.pop_front();
                    if (got_m !== e.master || got_d !== e.data || err_o !== e.err) begin
                        errors++;
                        $display("FAIL resp: got m%0d data=0x%08h err=%0b, required m%0d data=0x%08h err=%0b",
                                 got_m, got_d, err_o, e.master, e.data, e.err);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctl"}, {26'h0, busy_o, m0_ack_o, m1_ack_o, err_o, mem_rd_en_o, mem_wr_en_o}, 32'h0);
        check({name, "_data"}, m0_data_o | m1_data_o | mem_addr_o | mem_data_o, 32'h0);
    endtask

    // Issue one transaction from an idle DUT, queue its expected response and wait for the ack.
    task automatic run_txn(input logic m, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_data, input logic exp_err, input int max_cyc,
                           output int lat, output logic [1:0] en1,
                           output logic [31:0] addr1, output logic [31:0] data1);
        exp_t e;
        bit   seen;
        e.master = m;
        e.data   = exp_data;
        e.err    = exp_err;
        sb_q.push_back(e);
        if (m) begin
            m1_rd = rd; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_rd = rd; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
        end
        lat = 0; seen = 1'b0; en1 = 2'b00; addr1 = 32'h0; data1 = 32'h0;
        for (int i = 1; i <= max_cyc && !seen; i++) begin
            step();
            if (i == 1) begin
                en1   = {mem_rd_en_o, mem_wr_en_o};
                addr1 = mem_addr_o;
                data1 = mem_data_o;
            end
            if ((m && m1_ack_o) || (!m && m0_ack_o)) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL txn_wait: m%0d no ack within %0d cycles, required ack", m, max_cyc);
        end
        m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
        step();
    endtask

    initial begin
        int          lat;
        int          n_ack, fp0, fp1;
        logic [1:0]  en1;
        logic [31:0] addr1, data1;
        bit          seen;

        rst = 1'b1; ack_en = 1'b1; stray_ack = 1'b0;
        m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
        m0_addr = 32'h0; m0_wdata = 32'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        fp_m0_rd = 1'b0; fp_m1_rd = 1'b0;
        step(); step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // Single read by m0: enable at T+1, ack at T+3.
        run_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 10, lat, en1, addr1, data1);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_enables_t1", {30'h0, en1}, 32'h2);
        check("rd_addr", addr1, 32'h10);

        // m1 write, then read back.
        run_txn(1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 10, lat, en1, addr1, data1);
        check("wr_enables_t1", {30'h0, en1}, 32'h1);
        check("wr_data_out", data1, 32'h12345678);
        check("wr_mem_word", mem[8], 32'h12345678);
        run_txn(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 10, lat, en1, addr1, data1);
        check("m0_data_held", m0_data_o, 32'hDEADBEEF);

        // Read and write together execute as a write.
        run_txn(1'b1, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0, 10, lat, en1, addr1, data1);
        check("rdwr_enables_t1", {30'h0, en1}, 32'h1);
        check("rdwr_mem_word", mem[12], 32'hA5A5A5A5);

        // Timeout: memory never acknowledges.
        ack_en = 1'b0;
        run_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 30, lat, en1, addr1, data1);
        check("timeout_latency", 32'(lat), 32'd18);
        ack_en = 1'b1;

        // Stray memory ack while idle must be ignored.
        stray_ack = 1'b1;
        step(); step();
        stray_ack = 1'b0;
        check("stray_busy", {31'h0, busy_o}, 32'h0);
        step(); step();

        // Round-robin contention from reset: m0, m1, m0, m1.
        rst = 1'b1; step(); rst = 1'b0; step();
        sb_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        sb_q.push_back('{1'b1, 32'h12345678, 1'b0});
        sb_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        sb_q.push_back('{1'b1, 32'h12345678, 1'b0});
        m0_rd = 1'b1; m0_addr = 32'h10; m1_rd = 1'b1; m1_addr = 32'h20;
        n_ack = 0;
        for (int i = 0; i < 40 && n_ack < 4; i++) begin
            step();
            if (m0_ack_o || m1_ack_o) n_ack++;
        end
        m0_rd = 1'b0; m1_rd = 1'b0;
        check("rr_ack_count", 32'(n_ack), 32'd4);
        step();

        // Fixed priority: only m1 served while both held, then m0 once m1 drops.
        fp_m0_rd = 1'b1; fp_m1_rd = 1'b1;
        fp0 = 0; fp1 = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (fp_m0_ack_o) fp0++;
            if (fp_m1_ack_o) fp1++;
        end
        check("fp_m0_acks", 32'(fp0), 32'd0);
        check("fp_m1_acks", 32'(fp1), 32'd6);
        fp_m1_rd = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (fp_m0_ack_o) seen = 1'b1;
        end
        fp_m0_rd = 1'b0;
        check("fp_m0_served", {31'h0, seen}, 32'h1);
        step();
        check("fp_m0_data", fp_m0_data_o, 32'h140);
        check("fp_m1_data", fp_m1_data_o, 32'h180);
        check("fp_idle_ctl", {29'h0, fp_err_o, fp_busy_o, fp_mem_wr_en_o}, 32'h0);
        check("fp_mem_data", fp_mem_data_o, 32'h0);

        // Reset in the middle of WAIT: no ack, everything cleared.
        ack_en = 1'b0;
        m0_rd = 1'b1; m0_addr = 32'h10;
        step(); step(); step(); step();
        check("midop_busy", {31'h0, busy_o}, 32'h1);
        rst = 1'b1; m0_rd = 1'b0;
        step();
        check_outputs_zero("midop_reset");
        rst = 1'b0; ack_en = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of WAIT-state cycles allowed for mem_ack_i before the transaction is aborted.
REQ-002 The block SHALL have parameter ROUND_ROBIN, default 1, meaning 1 selects round-robin arbitration and 0 selects fixed priority with m1 (data port) always winning.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have ports m0_rd_en_i / m1_rd_en_i  input  1  read request from master N (m0 = instruction fetch, m1 = data).
REQ-006 The block SHALL have ports m0_wr_en_i / m1_wr_en_i  input  1  write request from master N.
REQ-007 The block SHALL have ports m0_addr_i / m1_addr_i  input  32  byte address from master N.
REQ-008 The block SHALL have ports m0_data_i / m1_data_i  input  32  write data from master N.
REQ-009 The block SHALL have ports m0_data_o / m1_data_o  output  32  read data returned to master N.
REQ-010 The block SHALL have ports m0_ack_o / m1_ack_o  output  1  one-cycle completion pulse to master N.
REQ-011 The block SHALL have port err_o  output  1  pulses with the master ack when the transaction timed out.
REQ-012 The block SHALL have port busy_o  output  1  high in every state other than IDLE.
REQ-013 The block SHALL have ports mem_rd_en_o, mem_wr_en_o  output  1 each  requests to the word memory.
REQ-014 The block SHALL have ports mem_addr_o, mem_data_o  output  32 each  address and write data to the memory.
REQ-015 The block SHALL have ports mem_data_i  input  32, and mem_ack_i  input  1  read data and registered acknowledge from the memory.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, and SHALL advance IDLE->ISSUE->WAIT->RESP->IDLE.
REQ-017 In IDLE with any request present, the block SHALL select a master, latch its op, addr and data plus the grant ID, and go to ISSUE.
REQ-018 The block SHALL treat a master as requesting when rd_en or wr_en is high; rd and wr together SHALL be executed as a write only.
REQ-019 On a round-robin contention, the master not granted last SHALL win; with ROUND_ROBIN=0 on contention, m1 SHALL win; the last-grant pointer SHALL update in RESP.
REQ-020 In ISSUE, exactly one of mem_rd_en_o / mem_wr_en_o SHALL be high for exactly one cycle, with mem_addr_o and mem_data_o carrying the latched values; addr SHALL pass unmodified.
REQ-021 mem_rd_en_o and mem_wr_en_o SHALL be 0 in all states other than ISSUE; mem_addr_o and mem_data_o SHALL hold the latched values.
REQ-022 In WAIT, a 5-bit-or-wider counter SHALL count cycles; when mem_ack_i=1, mem_data_i SHALL be captured (reads; 0 for writes) and the FSM SHALL go to RESP.
REQ-023 If the WAIT counter reaches TIMEOUT_CYCLES without mem_ack_i, the FSM SHALL go to RESP with captured data = 0 and an error flag set.
REQ-024 In RESP, only the granted master's ack_o SHALL be 1 for one cycle, its data_o SHALL equal the captured data, and err_o SHALL equal the error flag.
REQ-025 data_o SHALL be registered, holding its value until the next RESP for that master.
REQ-026 With a memory of 1-cycle ack and a request first seen in IDLE at cycle T, the mem enable SHALL be high at T+1 and the master ack SHALL be high at T+3.
REQ-027 Masters SHALL hold request signals stable until their ack; a request still high in the cycle after RESP SHALL be treated as a new transaction.
REQ-028 mem_ack_i arriving outside WAIT SHALL be ignored.
REQ-029 Requests arriving while busy SHALL wait; they SHALL NOT be lost while held.

Reset
REQ-030 On rst=1 at a clock edge, the FSM SHALL go to IDLE from any state, abandoning any in-flight transaction without an ack.
REQ-031 On reset, all outputs SHALL be 0, the counter SHALL be 0, and last-grant SHALL be m1, so that m0 wins the first round-robin tie.

Verification
REQ-032 Single read: m0 read at addr 0x10, memory word4=0xDEADBEEF -> mem_rd_en_o pulses at T+1, and m0_ack_o=1 with m0_data_o=0xDEADBEEF at T+3.
REQ-033 Write then read: m1 writes 0x12345678 to 0x20, then m1 reads 0x20 -> m1_data_o=0x12345678, and the write ack has m1_data_o=0.
REQ-034 Contention: m0 and m1 requests held continuously after reset -> grants are m0, m1, m0, m1; with ROUND_ROBIN=0 -> only m1 is served until it drops.
REQ-035 Timeout: mem_ack_i tied 0 and an m0 read -> at the 16th WAIT cycle, m0_ack_o=1, err_o=1 and m0_data_o=0.
REQ-036 Reset mid-op: rst asserted in WAIT -> next cycle busy_o=0, no ack is issued, and all outputs are 0.
REQ-037 rd+wr together: m1 asserts both with data 0xA5A5A5A5 -> mem_wr_en_o=1, mem_rd_en_o=0, and the memory is updated.
